// File: rtl/elastic_pipe_reg_if.sv
// Handshake, payload and hazard-tap bundle for elastic_pipe_reg.
// The pipe itself uses the slave view; its environment uses the master view.
interface elastic_pipe_reg_if #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 2,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic [DEST_W-1:0]       in_dest;
  logic                    in_we;
  logic [FLAG_W-1:0]       in_flags;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  logic [DEST_W-1:0]       out_dest;
  logic                    out_we;
  logic [FLAG_W-1:0]       out_flags;
  logic [DEPTH*DEST_W-1:0] hz_dest;
  logic [DEPTH-1:0]        hz_we;
  logic [OCC_W-1:0]        occupancy;
  logic [CNT_W-1:0]        kill_count;

  modport slave (
    input  in_valid, in_data, in_dest, in_we, in_flags, out_ready,
    output in_ready, out_valid, out_data, out_dest, out_we, out_flags,
           hz_dest, hz_we, occupancy, kill_count
  );

  modport master (
    output in_valid, in_data, in_dest, in_we, in_flags, out_ready,
    input  in_ready, out_valid, out_data, out_dest, out_we, out_flags,
           hz_dest, hz_we, occupancy, kill_count
  );
endinterface

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic write-back register with backpressure, bubble collapse,
// whole-pipe flush, per-stage hazard taps and a saturating flush-kill counter.
module elastic_pipe_reg #(
  parameter int DATA_W = 8,
  parameter int DEST_W = 2,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic reset,
  input logic flush,
  elastic_pipe_reg_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PW    = DATA_W + DEST_W + 1 + FLAG_W;
  localparam int KW    = CNT_W + OCC_W;
  localparam logic [KW-1:0] KILL_MAX = KW'({CNT_W{1'b1}});

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][PW-1:0] payload_q, payload_d;
  logic [CNT_W-1:0]         kill_q, kill_d;

  logic [DEPTH-1:0]         adv;
  logic [DEPTH-1:0]         src_valid;
  logic [DEPTH-1:0][PW-1:0] src_payload;
  logic                     in_ready_w;
  logic                     in_fire;
  logic [OCC_W-1:0]         occ;
  logic [KW-1:0]            kill_sum;
  logic [DEPTH*DEST_W-1:0]  hz_dest_w;
  logic [DEPTH-1:0]         hz_we_w;
  logic                     last_we;

  // A stage may advance if it or any stage ahead of it is empty, or the sink is ready.
  always_comb begin
    adv = '0;
    for (int i = 0; i < DEPTH; i++) begin
      adv[i] = bus.out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!valid_q[j]) adv[i] = 1'b1;
      end
    end
  end

  assign in_ready_w = adv[0] & ~flush;
  assign in_fire    = bus.in_valid & in_ready_w;

  always_comb begin
    src_valid      = '0;
    src_payload    = '0;
    src_valid[0]   = in_fire;
    src_payload[0] = {bus.in_data, bus.in_dest, bus.in_we, bus.in_flags};
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i]   = valid_q[i-1];
      src_payload[i] = payload_q[i-1];
    end
  end

  // Payload only captures a live source, so empty stages keep stale but defined data.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        valid_d[i] = 1'b0;
      end else if (adv[i]) begin
        valid_d[i] = src_valid[i];
        if (src_valid[i]) payload_d[i] = src_payload[i];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(valid_q[i]);
    end
  end

  always_comb begin
    kill_sum = KW'(kill_q) + KW'(occ);
    kill_d   = kill_q;
    if (flush) begin
      kill_d = (kill_sum > KILL_MAX) ? {CNT_W{1'b1}} : kill_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      payload_q <= '0;
      kill_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      kill_q    <= kill_d;
    end
  end

  always_comb begin
    hz_dest_w = '0;
    hz_we_w   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_dest_w[i*DEST_W +: DEST_W] = payload_q[i][FLAG_W+1 +: DEST_W];
      hz_we_w[i] = valid_q[i] & payload_q[i][FLAG_W] & ~flush;
    end
  end

  assign {bus.out_data, bus.out_dest, last_we, bus.out_flags} = payload_q[DEPTH-1];
  assign bus.out_valid  = valid_q[DEPTH-1] & ~flush;
  assign bus.out_we     = bus.out_valid & last_we;
  assign bus.in_ready   = in_ready_w;
  assign bus.hz_dest    = hz_dest_w;
  assign bus.hz_we      = hz_we_w;
  assign bus.occupancy  = occ;
  assign bus.kill_count = kill_q;
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Randomised and directed bench for elastic_pipe_reg against a queue-of-entries model
// where each entry steps one slot toward the output unless blocked by the entry ahead.
module tb_elastic_pipe_reg;
  localparam int DATA_W = 8;
  localparam int DEST_W = 2;
  localparam int FLAG_W = 4;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;
  localparam int KILL_MAX = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;

  elastic_pipe_reg_if #(.DATA_W(DATA_W), .DEST_W(DEST_W), .FLAG_W(FLAG_W),
                        .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  elastic_pipe_reg #(.DATA_W(DATA_W), .DEST_W(DEST_W), .FLAG_W(FLAG_W),
                     .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int                pos;
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              we;
    logic [FLAG_W-1:0] flags;
  } entry_t;

  entry_t                  pipe[$];
  entry_t                  newEntry;
  int                      kills = 0;
  int                      limit;
  int                      np;
  logic                    expOv;
  logic                    expInReady;
  logic [DEPTH-1:0]        hzWe;
  logic [DEPTH*DEST_W-1:0] hzDest;
  logic [DEPTH*DEST_W-1:0] hzMask;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [DEST_W-1:0] ds,
                               input logic w, input logic [FLAG_W-1:0] f, input logic fl, input logic ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_dest   = ds;
    bus.in_we     = w;
    bus.in_flags  = f;
    flush         = fl;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task stepModel();
    if (flush) begin
      kills = kills + pipe.size();
      if (kills > KILL_MAX) kills = KILL_MAX;
      pipe.delete();
      return;
    end
    expInReady = (pipe.size() < DEPTH) || bus.out_ready;
    if (pipe.size() > 0 && pipe[0].pos == DEPTH - 1 && bus.out_ready) void'(pipe.pop_front());
    limit = DEPTH;
    foreach (pipe[k]) begin
      np = (pipe[k].pos + 1 < limit - 1) ? pipe[k].pos + 1 : limit - 1;
      pipe[k].pos = np;
      limit = np;
    end
    if (bus.in_valid && expInReady) begin
      newEntry.pos   = 0;
      newEntry.data  = bus.in_data;
      newEntry.dest  = bus.in_dest;
      newEntry.we    = bus.in_we;
      newEntry.flags = bus.in_flags;
      pipe.push_back(newEntry);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      pipe.delete();
      kills = 0;
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
      checkOutput("rst_out_data", 64'(bus.out_data), 64'(0));
      checkOutput("rst_out_dest", 64'(bus.out_dest), 64'(0));
      checkOutput("rst_out_we", 64'(bus.out_we), 64'(0));
      checkOutput("rst_out_flags", 64'(bus.out_flags), 64'(0));
      checkOutput("rst_hz_we", 64'(bus.hz_we), 64'(0));
      checkOutput("rst_hz_dest", 64'(bus.hz_dest), 64'(0));
      checkOutput("rst_occupancy", 64'(bus.occupancy), 64'(0));
      checkOutput("rst_kill_count", 64'(bus.kill_count), 64'(0));
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(!flush));
    end else begin
      expOv = (pipe.size() > 0) && (pipe[0].pos == DEPTH - 1) && !flush;
      checkOutput("out_valid", 64'(bus.out_valid), 64'(expOv));
      if (expOv) begin
        checkOutput("out_data", 64'(bus.out_data), 64'(pipe[0].data));
        checkOutput("out_dest", 64'(bus.out_dest), 64'(pipe[0].dest));
        checkOutput("out_flags", 64'(bus.out_flags), 64'(pipe[0].flags));
        checkOutput("out_we", 64'(bus.out_we), 64'(pipe[0].we));
      end else begin
        checkOutput("out_we_idle", 64'(bus.out_we), 64'(0));
      end
      expInReady = ((pipe.size() < DEPTH) || bus.out_ready) && !flush;
      checkOutput("in_ready", 64'(bus.in_ready), 64'(expInReady));
      checkOutput("occupancy", 64'(bus.occupancy), 64'(pipe.size()));
      checkOutput("kill_count", 64'(bus.kill_count), 64'(kills));
      hzWe = '0;
      hzDest = '0;
      hzMask = '0;
      foreach (pipe[k]) begin
        hzWe[pipe[k].pos] = pipe[k].we && !flush;
        hzDest[pipe[k].pos*DEST_W +: DEST_W] = pipe[k].dest;
        hzMask[pipe[k].pos*DEST_W +: DEST_W] = '1;
      end
      checkOutput("hz_we", 64'(bus.hz_we), 64'(hzWe));
      checkOutput("hz_dest", 64'(bus.hz_dest & hzMask), 64'(hzDest));
      stepModel();
    end
  end

  initial begin
    applyStimulus(1'b1, 8'h5A, 2'd2, 1'b1, 4'hF, 1'b0, 1'b1);
    cycle();
    cycle();
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("reset_occupancy", 64'(bus.occupancy), 64'(0));
    checkOutput("reset_out_data", 64'(bus.out_data), 64'(0));
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    reset = 1'b1;
    cycle();
    cycle();
    checkOutput("release_occupancy", 64'(bus.occupancy), 64'(0));
    checkOutput("release_out_valid", 64'(bus.out_valid), 64'(0));

    // Streaming at full rate: first result two edges after first accept.
    applyStimulus(1'b1, 8'h11, 2'd1, 1'b1, 4'h1, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b1, 8'h22, 2'd2, 1'b1, 4'h2, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b1, 8'h33, 2'd3, 1'b1, 4'h3, 1'b0, 1'b1);
    checkOutput("stream_valid0", 64'(bus.out_valid), 64'(1));
    checkOutput("stream_data0", 64'(bus.out_data), 64'(8'h11));
    cycle();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("stream_data1", 64'(bus.out_data), 64'(8'h22));
    cycle();
    checkOutput("stream_data2", 64'(bus.out_data), 64'(8'h33));
    cycle();
    checkOutput("stream_drained", 64'(bus.out_valid), 64'(0));

    // Backpressure: full pipe stalls the third push until the sink is ready.
    applyStimulus(1'b1, 8'hA1, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'hA2, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'hA3, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("bp_occupancy", 64'(bus.occupancy), 64'(2));
    checkOutput("bp_in_ready", 64'(bus.in_ready), 64'(0));
    cycle();
    checkOutput("bp_hold_occ", 64'(bus.occupancy), 64'(2));
    applyStimulus(1'b1, 8'hA3, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("bp_release_ready", 64'(bus.in_ready), 64'(1));
    checkOutput("bp_data0", 64'(bus.out_data), 64'(8'hA1));
    cycle();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("bp_data1", 64'(bus.out_data), 64'(8'hA2));
    cycle();
    checkOutput("bp_data2", 64'(bus.out_data), 64'(8'hA3));
    cycle();
    checkOutput("bp_drained", 64'(bus.out_valid), 64'(0));

    // Bubble collapse with hazard taps: older entry dest 3 no write, younger dest 1 write.
    applyStimulus(1'b1, 8'hB1, 2'd3, 1'b0, 4'h5, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'hB2, 2'd1, 1'b1, 4'h6, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("bubble_occupancy", 64'(bus.occupancy), 64'(2));
    checkOutput("bubble_out_data", 64'(bus.out_data), 64'(8'hB1));
    checkOutput("hz_dest_taps", 64'(bus.hz_dest), 64'(4'b1101));
    checkOutput("hz_we_taps", 64'(bus.hz_we), 64'(2'b01));
    checkOutput("hz_out_valid", 64'(bus.out_valid), 64'(1));
    checkOutput("hz_out_we", 64'(bus.out_we), 64'(0));
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    cycle();
    checkOutput("bubble_second", 64'(bus.out_data), 64'(8'hB2));
    checkOutput("bubble_second_we", 64'(bus.out_we), 64'(1));
    cycle();

    // Flush with two live write entries and a pending input.
    applyStimulus(1'b1, 8'hF1, 2'd1, 1'b1, 4'h0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'hF2, 2'd2, 1'b1, 4'h0, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 8'hF3, 2'd3, 1'b1, 4'h0, 1'b1, 1'b1);
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("flush_hz_we", 64'(bus.hz_we), 64'(0));
    checkOutput("flush_in_ready", 64'(bus.in_ready), 64'(0));
    cycle();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("flush_occupancy", 64'(bus.occupancy), 64'(0));
    checkOutput("flush_kill_count", 64'(bus.kill_count), 64'(2));
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("flush_no_ghost", 64'(bus.out_valid), 64'(0));
    end

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, DATA_W'($urandom), DEST_W'($urandom),
                    1'($urandom), FLAG_W'($urandom), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 9) < 6);
      cycle();
    end

    // Asynchronous reset mid-operation clears state without waiting for an edge.
    applyStimulus(1'b1, 8'hC3, 2'd1, 1'b1, 4'h7, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_occupancy", 64'(bus.occupancy), 64'(0));
    checkOutput("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("midrst_kill_count", 64'(bus.kill_count), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;

    // Repeated two-entry flushes drive the kill counter into saturation.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, DATA_W'(i), 2'd0, 1'b1, 4'h0, 1'b0, 1'b0);
      cycle();
      cycle();
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b1, 1'b0);
      cycle();
      if (i == 9) checkOutput("kill_count_20", 64'(bus.kill_count), 64'(20));
    end
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("kill_count_sat", 64'(bus.kill_count), 64'(255));
    cycle();
    checkOutput("kill_count_hold", 64'(bus.kill_count), 64'(255));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
